// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder sequencer: radix-2 restoring division,
// one quotient bit per cycle, with busy stall and a one-cycle done pulse.
module div_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] quo_q, rem_q, dvsr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q, neg_rem_q, is_rem_q;

    // Operand decode for the IDLE/accept cycle; unknown funct3 codes fall to DIVU.
    logic             is_rem_c, is_signed_c, dvd_neg_c, dvs_neg_c;
    logic             accept_c, div_zero_c, overflow_c, special_c;
    logic [WIDTH-1:0] dvd_abs_c, dvs_abs_c, special_res_c;

    always_comb begin
        is_rem_c      = funct3_i[2] & funct3_i[1];
        is_signed_c   = funct3_i[2] & ~funct3_i[0];
        dvd_neg_c     = is_signed_c & dividend_i[WIDTH-1];
        dvs_neg_c     = is_signed_c & divisor_i[WIDTH-1];
        dvd_abs_c     = dvd_neg_c ? (WIDTH'(0) - dividend_i) : dividend_i;
        dvs_abs_c     = dvs_neg_c ? (WIDTH'(0) - divisor_i) : divisor_i;
        accept_c      = start_i & ~flush_i;
        div_zero_c    = (divisor_i == '0);
        overflow_c    = is_signed_c & (dividend_i == INT_MIN) & (divisor_i == ALL_ONES);
        special_c     = div_zero_c | overflow_c;
        special_res_c = '0;
        if (div_zero_c) begin
            special_res_c = is_rem_c ? dividend_i : ALL_ONES;
        end else if (overflow_c) begin
            special_res_c = is_rem_c ? '0 : INT_MIN;
        end
    end

    // One restoring step; the partial remainder is widened by one bit for the compare.
    logic [WIDTH:0]   rem_sh_c, diff_c;
    logic             ge_c;
    logic [WIDTH-1:0] rem_nxt_c, quo_nxt_c, final_c;

    always_comb begin
        rem_sh_c  = {rem_q, quo_q[WIDTH-1]};
        diff_c    = rem_sh_c - {1'b0, dvsr_q};
        ge_c      = ~diff_c[WIDTH];
        rem_nxt_c = ge_c ? diff_c[WIDTH-1:0] : rem_sh_c[WIDTH-1:0];
        quo_nxt_c = {quo_q[WIDTH-2:0], ge_c};
        if (is_rem_q) begin
            final_c = neg_rem_q ? (WIDTH'(0) - rem_nxt_c) : rem_nxt_c;
        end else begin
            final_c = neg_quo_q ? (WIDTH'(0) - quo_nxt_c) : quo_nxt_c;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = special_c ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // done_o is registered off the DONE state, so it pulses in the cycle after DONE.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            quo_q     <= '0;
            rem_q     <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            result_o  <= '0;
        end else begin
            state_q <= state_d;
            busy_o  <= (state_d != IDLE);
            done_o  <= (state_q == DONE) & ~flush_i;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        quo_q     <= dvd_abs_c;
                        dvsr_q    <= dvs_abs_c;
                        rem_q     <= '0;
                        cnt_q     <= CNT_LAST;
                        is_rem_q  <= is_rem_c;
                        neg_quo_q <= dvd_neg_c ^ dvs_neg_c;
                        neg_rem_q <= dvd_neg_c;
                        if (special_c) begin
                            result_o <= special_res_c;
                        end
                    end
                end
                CALC: begin
                    if (!flush_i) begin
                        quo_q <= quo_nxt_c;
                        rem_q <= rem_nxt_c;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == '0) begin
                            result_o <= final_c;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: vector table plus flush/reset/busy corner sequences.
module tb_div_sequencer;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             flush;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    div_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .start_i    (start),
        .flush_i    (flush),
        .funct3_i   (funct3),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents one operation in the current cycle and waits (bounded) for done.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cycles, output logic [31:0] res);
        funct3      = f3;
        dividend    = a;
        divisor     = b;
        start       = 1'b1;
        lat         = 0;
        busy_cycles = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cycles++;
        end
        res = result;
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    int          lat, bcy, pulses;
    logic [31:0] res;

    initial begin
        vecs[0]  = '{3'b100, 32'd100,        32'd7,          32'd14,         34};
        vecs[1]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
        vecs[2]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
        vecs[3]  = '{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  2};
        vecs[4]  = '{3'b111, 32'd5,          32'd0,          32'd5,          2};
        vecs[5]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2};
        vecs[6]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2};
        vecs[7]  = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
        vecs[8]  = '{3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};
        vecs[9]  = '{3'b100, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         34};
        vecs[10] = '{3'b110, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  34};
        vecs[11] = '{3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          34};
        vecs[12] = '{3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34};
        vecs[13] = '{3'b000, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  34};
        vecs[14] = '{3'b111, 32'hFFFF_FFFF,  32'h10,         32'hF,          34};
        vecs[15] = '{3'b101, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          34};
        vecs[16] = '{3'b111, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  34};
        vecs[17] = '{3'b110, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  2};
        vecs[18] = '{3'b100, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  2};

        reset_n  = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        funct3   = 3'b000;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy",   32'(busy),  32'd0);
        check("reset_done",   32'(done),  32'd0);
        check("reset_result", result,     32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Table: ops issued back-to-back, each start in the cycle done is seen.
        for (int i = 0; i < NVEC; i++) begin
            check($sformatf("v%0d_busy_at_start", i), 32'(busy), 32'd0);
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, lat, bcy, res);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_busy_cycles", i), 32'(bcy), 32'(vecs[i].lat - 1));
            check($sformatf("v%0d_result", i), res, vecs[i].exp);
        end
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);

        // Flush at CALC iteration 10: abort, no done, result kept (last was 0xFFFFFFFF).
        funct3 = 3'b101; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        count_done(40, pulses);
        check("flush_no_done", 32'(pulses), 32'd0);
        check("flush_result_kept", result, 32'hFFFF_FFFF);
        run_op(3'b101, 32'd9, 32'd3, lat, bcy, res);
        check("post_flush_latency", 32'(lat), 32'd34);
        check("post_flush_result", res, 32'd3);

        // Start together with flush in IDLE is dropped.
        funct3 = 3'b101; dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);
        count_done(40, pulses);
        check("flush_start_no_done", 32'(pulses), 32'd0);
        check("flush_start_result", result, 32'd3);

        // Start while busy is ignored: DIV 100/7 runs to completion alone.
        funct3 = 3'b100; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 5) begin
                funct3 = 3'b101; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        check("busy_start_latency", 32'(lat), 32'd34);
        check("busy_start_result", result, 32'd14);
        count_done(40, pulses);
        check("busy_start_no_extra_done", 32'(pulses), 32'd0);

        // Reset mid-CALC clears everything.
        funct3 = 3'b100; dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midreset_busy",   32'(busy), 32'd0);
        check("midreset_done",   32'(done), 32'd0);
        check("midreset_result", result,    32'd0);
        count_done(40, pulses);
        check("midreset_no_done", 32'(pulses), 32'd0);
        run_op(3'b100, 32'd1000, 32'd7, lat, bcy, res);
        check("post_reset_latency", 32'(lat), 32'd34);
        check("post_reset_result", res, 32'd142);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
